regbank_ctrl: RTL and testbench
===============================

# regbank_ctrl

Command sequencer that drives the 4x8 register bank from the initiator side. It accepts one register-to-register command at a time over a valid/ready handshake. For each command it issues the bank read addresses, captures both operands, computes an 8-bit result and issues a single write-back. It sits between the instruction/test front end and the register bank and owns every bank read-address and write port signal.

## Interface
Parameters:
- DW, 8, data width; must match bank word width.
- AW, 2, register address width (4 registers).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high; shared with the bank.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command (IDLE and rst low).
- cmd_op  in  2  00 LDI, 01 ADD, 10 SUB, 11 MOV.
- cmd_dst  in  AW  destination register.
- cmd_src0  in  AW  first source register.
- cmd_src1  in  AW  second source register.
- cmd_imm  in  DW  immediate for LDI.
- add_rd0  out  AW  bank read address port 0.
- add_rd1  out  AW  bank read address port 1.
- rd0  in  DW  bank read data port 0 (combinational from add_rd0).
- rd1  in  DW  bank read data port 1.
- wr_en  out  1  bank write enable.
- add_wr  out  AW  bank write address.
- wr_data  out  DW  bank write data.
- result  out  DW  last computed result.
- flag_c  out  1  carry/borrow of last ADD/SUB.
- done  out  1  one-cycle pulse; the write-back cycle of a command.

## Operation
- FSM states are IDLE, READ, EXEC and WRITE. The reset state is IDLE.
- IDLE: cmd_ready=1.
  - The command is accepted on the posedge where cmd_valid and cmd_ready are both 1.
  - On accept, op, dst, src0, src1 and imm are latched into op_q, dst_q, src0_q, src1_q and imm_q, and the FSM goes to READ.
- READ: add_rd0=src0_q and add_rd1=src1_q. These addresses are driven from the latched fields in every state.
  - At the end of the cycle, rd0 and rd1 are registered into opa_q and opb_q.
  - Next state is EXEC.
- EXEC: the result is computed and registered into result_q and flag_c. Next state is WRITE.
  - LDI: result = imm_q; flag_c = 0.
  - ADD: {flag_c, result} = opa_q + opb_q, 9-bit sum; result is mod 256.
  - SUB: see Configuration.
  - MOV: result = opa_q; flag_c = 0.
- WRITE: wr_en=1, add_wr=dst_q, wr_data=result_q, done=1. The bank captures the value on the closing edge. Next state is IDLE.
- Outside WRITE: wr_en=0 and done=0. add_wr and wr_data continue to follow dst_q and result_q.
- While not in IDLE, cmd_ready=0. cmd_valid is ignored and held commands are not lost; the producer keeps them valid.
- Reset mid-command:
  - The FSM returns to IDLE immediately and all registers clear.
  - No write is issued. The partially executed command is discarded.
- Reset values: cmd_ready=0 while rst is high and 1 after release. All other outputs are 0: add_rd0, add_rd1, wr_en, add_wr, wr_data, result, flag_c and done.

## Timing
- Command accepted on edge E0. The FSM is in READ during cycle 1, EXEC during cycle 2 and WRITE during cycle 3. The bank holds the new value after edge E3.
- cmd_ready is high again in cycle 4.
- Fixed latency is 4 cycles per command for all ops. Maximum throughput is 1 command per 4 cycles.
- There is no read-after-write hazard. The next command's READ is at least 2 cycles after the previous write edge, so a back-to-back dependent command sees the updated value.
- The bank read is combinational. Operands must be stable one cycle after add_rd* change, which is always met in READ.

## Configuration
- Macro: CTRL_SUB_EN.
- Defined: op 10 computes result = opa_q − opb_q mod 256. flag_c = 1 when opa_q < opb_q (borrow), else 0. The result is written back.
- Not defined:
  - op 10 runs the same 4-cycle sequence and done still pulses.
  - wr_en stays 0 in WRITE.
  - result and flag_c keep their previous values.
  - No subtractor is synthesized.

## Test plan
- Reset, then LDI r1←0x2A, then MOV r3←r1. Required: bank r1=0x2A, then r3=0x2A; result=0x2A; done pulses 3 cycles after each accept; flag_c=0.
- LDI r0←0xF0 and r1←0x20, then ADD r2←r0+r1. Required: r2=0x10, flag_c=1, wr_en high only in the WRITE cycle with add_wr=2.
- r0=0x05, r1=0x07, SUB r2←r0−r1. With CTRL_SUB_EN: r2=0xFE, flag_c=1. Without it: wr_en never asserts, r2 is unchanged, done still pulses.
- r0=0x03, cmd_valid held high with two ADD r0←r0+r0 commands. Required: the second is accepted exactly 4 cycles after the first; r0=0x06, then 0x0C; cmd_ready=0 in cycles 1–3.
- Assert rst during EXEC of ADD r2←r0+r1. Required: wr_en never asserts, all outputs are 0 during reset, cmd_ready=1 on the first cycle after rst deasserts, and the bank r2 reads 0x00.

Source files
------------

// File: rtl/regbank_ctrl.sv
// Command sequencer for the 4x8 register bank: READ -> EXEC -> WRITE per accepted command.
// Optional macro CTRL_SUB_EN enables the SUB opcode; otherwise SUB runs the sequence without writing.
module regbank_ctrl #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_src0,
  input  logic [AW-1:0] cmd_src1,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] add_rd0,
  output logic [AW-1:0] add_rd1,
  input  logic [DW-1:0] rd0,
  input  logic [DW-1:0] rd1,
  output logic          wr_en,
  output logic [AW-1:0] add_wr,
  output logic [DW-1:0] wr_data,
  output logic [DW-1:0] result,
  output logic          flag_c,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MOV = 2'b11;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] src0_q, src0_d;
  logic [AW-1:0] src1_q, src1_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [DW-1:0] result_q, result_d;
  logic          flag_q, flag_d;
  logic [DW:0]   sum_s;
  logic          write_ok_s;

  assign sum_s = {1'b0, opa_q} + {1'b0, opb_q};

`ifdef CTRL_SUB_EN
  logic [DW:0] diff_s;
  // The extra top bit of the widened difference is the borrow (opa < opb).
  assign diff_s     = {1'b0, opa_q} - {1'b0, opb_q};
  assign write_ok_s = 1'b1;
`else
  assign write_ok_s = (op_q != OP_SUB);
`endif

  // State and datapath registers; reset discards any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      dst_q    <= '0;
      src0_q   <= '0;
      src1_q   <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      src0_q   <= src0_d;
      src1_q   <= src1_d;
      imm_q    <= imm_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  // Next-state and datapath update for the four-cycle command sequence.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    src0_d   = src0_q;
    src1_d   = src1_q;
    imm_d    = imm_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    flag_d   = flag_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          dst_d   = cmd_dst;
          src0_d  = cmd_src0;
          src1_d  = cmd_src1;
          imm_d   = cmd_imm;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        opa_d   = rd0;
        opb_d   = rd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_LDI: begin
            result_d = imm_q;
            flag_d   = 1'b0;
          end
          OP_ADD: begin
            result_d = sum_s[DW-1:0];
            flag_d   = sum_s[DW];
          end
          OP_SUB: begin
`ifdef CTRL_SUB_EN
            result_d = diff_s[DW-1:0];
            flag_d   = diff_s[DW];
`else
            result_d = result_q;
            flag_d   = flag_q;
`endif
          end
          OP_MOV: begin
            result_d = opa_q;
            flag_d   = 1'b0;
          end
          default: begin
            result_d = result_q;
            flag_d   = flag_q;
          end
        endcase
        state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign add_rd0   = src0_q;
  assign add_rd1   = src1_q;
  assign wr_en     = (state_q == S_WRITE) && write_ok_s;
  assign add_wr    = dst_q;
  assign wr_data   = result_q;
  assign result    = result_q;
  assign flag_c    = flag_q;
  assign done      = (state_q == S_WRITE);

endmodule

// File: tb/tb_regbank_ctrl.sv
// Directed bench for regbank_ctrl with a behavioural bank and command-level reference model.
module tb_regbank_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_dst, cmd_src0, cmd_src1;
  logic [7:0] cmd_imm;
  logic [1:0] add_rd0, add_rd1, add_wr;
  logic [7:0] rd0, rd1, wr_data, result;
  logic       wr_en, flag_c, done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr_addr = 0;

  regbank_ctrl #(.DW(8), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_imm(cmd_imm),
    .add_rd0(add_rd0), .add_rd1(add_rd1), .rd0(rd0), .rd1(rd1),
    .wr_en(wr_en), .add_wr(add_wr), .wr_data(wr_data),
    .result(result), .flag_c(flag_c), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register bank attached to the controller: combinational read, clocked write.
  logic [7:0] bank [4];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) bank[i] <= 8'h00;
    end else if (wr_en) begin
      bank[add_wr] <= wr_data;
    end
  end
  assign rd0 = bank[add_rd0];
  assign rd1 = bank[add_rd1];

  // Reference: command effect computed from plain arithmetic on the model bank.
  function automatic logic [10:0] model_exec(input logic [1:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] imm);
    int s;
    logic [7:0] r;
    logic f, we, upd;
    s = 0; r = 8'h00; f = 1'b0; we = 1'b1; upd = 1'b1;
    case (op)
      2'b00: r = imm;
      2'b01: begin
        s = int'(a) + int'(b);
        r = 8'(s % 256);
        f = (s > 255);
      end
      2'b10: begin
`ifdef CTRL_SUB_EN
        s = int'(a) - int'(b);
        r = 8'((s + 256) % 256);
        f = (a < b);
`else
        upd = 1'b0;
        we  = 1'b0;
`endif
      end
      default: r = a;
    endcase
    return {upd, we, f, r};
  endfunction

  int         m_phase;
  logic [7:0] mbank [4];
  logic [7:0] m_res, p_res;
  logic       m_flag, p_flag, p_we, p_upd;
  logic [1:0] m_dst, m_src0, m_src1;

  // Model timeline: accept, two internal cycles, then the write-back cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_res <= 8'h00; m_flag <= 1'b0;
      p_res <= 8'h00; p_flag <= 1'b0; p_we <= 1'b0; p_upd <= 1'b0;
      m_dst <= 2'd0; m_src0 <= 2'd0; m_src1 <= 2'd0;
      for (int i = 0; i < 4; i++) mbank[i] <= 8'h00;
    end else begin
      case (m_phase)
        0: if (cmd_valid) begin
          {p_upd, p_we, p_flag, p_res} <= model_exec(cmd_op, mbank[cmd_src0], mbank[cmd_src1], cmd_imm);
          m_dst <= cmd_dst; m_src0 <= cmd_src0; m_src1 <= cmd_src1;
          m_phase <= 1;
        end
        1: m_phase <= 2;
        2: begin
          if (p_upd) begin
            m_res <= p_res;
            m_flag <= p_flag;
          end
          m_phase <= 3;
        end
        3: begin
          if (p_we) mbank[m_dst] <= p_res;
          m_phase <= 0;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle output comparison against the model, plus write/done monitors.
  initial begin
    logic [25:0] act_v, exp_v;
    @(posedge clk);
    forever begin
      @(negedge clk);
      act_v = {cmd_ready, done, wr_en, add_rd0, add_rd1, add_wr, wr_data, result, flag_c};
      exp_v = {(m_phase == 0) && !rst, m_phase == 3, (m_phase == 3) && p_we,
               m_src0, m_src1, m_dst, m_res, m_res, m_flag};
      chk("cycle_outputs", 32'(act_v), 32'(exp_v));
      if (wr_en) begin
        wr_cnt++;
        last_wr_addr = int'(add_wr);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] s0,
                      input logic [1:0] s1, input logic [7:0] imm, output int acc);
    bit ok;
    ok = 1'b0;
    acc = 0;
    cmd_op = op; cmd_dst = dst; cmd_src0 = s0; cmd_src1 = s1; cmd_imm = imm;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int acc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin
        chk("done_cycle", 32'(cyc - acc + 1), 32'd3);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] s0,
                     input logic [1:0] s1, input logic [7:0] imm);
    int acc;
    send(op, dst, s0, s1, imm, acc);
    cmd_valid = 1'b0;
    wait_done(acc);
    wait_idle();
  endtask

  initial begin
    int acc1, acc2;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dst = 2'd0; cmd_src0 = 2'd0; cmd_src1 = 2'd0;
    cmd_imm = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(cmd_ready), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // LDI then MOV
    run(2'b00, 2'd1, 2'd0, 2'd0, 8'h2A);
    run(2'b11, 2'd3, 2'd1, 2'd0, 8'h00);
    chk("ldi_r1", 32'(bank[1]), 32'h2A);
    chk("mov_r3", 32'(bank[3]), 32'h2A);
    chk("mov_result", 32'(result), 32'h2A);
    chk("mov_flag", 32'(flag_c), 32'd0);

    // ADD with carry out
    run(2'b00, 2'd0, 2'd0, 2'd0, 8'hF0);
    run(2'b00, 2'd1, 2'd0, 2'd0, 8'h20);
    wr_cnt = 0;
    run(2'b01, 2'd2, 2'd0, 2'd1, 8'h00);
    chk("add_r2", 32'(bank[2]), 32'h10);
    chk("add_flag", 32'(flag_c), 32'd1);
    chk("add_wr_count", 32'(wr_cnt), 32'd1);
    chk("add_wr_addr", 32'(last_wr_addr), 32'd2);

    // SUB with borrow, or no write-back when SUB is not built
    run(2'b00, 2'd0, 2'd0, 2'd0, 8'h05);
    run(2'b00, 2'd1, 2'd0, 2'd0, 8'h07);
    wr_cnt = 0;
    run(2'b10, 2'd2, 2'd0, 2'd1, 8'h00);
`ifdef CTRL_SUB_EN
    chk("sub_r2", 32'(bank[2]), 32'hFE);
    chk("sub_flag", 32'(flag_c), 32'd1);
    chk("sub_wr_count", 32'(wr_cnt), 32'd1);
`else
    chk("sub_r2_kept", 32'(bank[2]), 32'h10);
    chk("sub_result_kept", 32'(result), 32'h07);
    chk("sub_wr_count", 32'(wr_cnt), 32'd0);
`endif

    // Two dependent ADDs with cmd_valid held high
    run(2'b00, 2'd0, 2'd0, 2'd0, 8'h03);
    send(2'b01, 2'd0, 2'd0, 2'd0, 8'h00, acc1);
    send(2'b01, 2'd0, 2'd0, 2'd0, 8'h00, acc2);
    cmd_valid = 1'b0;
    chk("b2b_spacing", 32'(acc2 - acc1), 32'd4);
    wait_done(acc2);
    wait_idle();
    chk("b2b_r0", 32'(bank[0]), 32'h0C);
    chk("b2b_result", 32'(result), 32'h0C);

    // Reset during EXEC of ADD r2 <- r0 + r1
    send(2'b01, 2'd2, 2'd0, 2'd1, 8'h00, acc1);
    cmd_valid = 1'b0;
    wr_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_midrst", 32'(cmd_ready), 32'd1);
    chk("midrst_r2", 32'(bank[2]), 32'h00);
    repeat (3) @(negedge clk);
    chk("midrst_no_write", 32'(wr_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
